// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding and the zero-divisor quotient pattern.
package alu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Wide enough for the largest legal operand; users slice the low bits.
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_sub_step
  import alu_pkg::*;
#(
  parameter int size = 4
) (
  input  logic [size:0]   partial_rem,
  input  logic            dividend_msb,
  input  logic [size-1:0] divisor,
  output logic [size:0]   next_rem,
  output logic            q_bit
);

  logic [size:0] shifted;
  logic [size:0] trial;
  logic          unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is never set.
  assign unused_rem_msb = partial_rem[size];

  assign shifted  = {partial_rem[size-1:0], dividend_msb};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[size];
  assign next_rem = q_bit ? trial : shifted;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a shared
// compare/subtract stage, with a start/busy/done handshake.
module div_seq_ctrl
  import alu_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [size-1:0] in_a,
  input  logic [size-1:0] in_b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;

  div_state_e      state_q, state_d;
  logic [size-1:0] dividend_q, dividend_d;
  logic [size-1:0] divisor_q, divisor_d;
  logic [size:0]   prem_q, prem_d;
  logic [CW-1:0]   count_q, count_d;
  logic [size-1:0] quot_q, quot_d;
  logic [size-1:0] rem_q, rem_d;
  logic            dz_q, dz_d;

  logic [size:0]   stepRem;
  logic            stepBit;

  div_sub_step #(
    .size(size)
  ) u_step (
    .partial_rem (prem_q),
    .dividend_msb(dividend_q[size-1]),
    .divisor     (divisor_q),
    .next_rem    (stepRem),
    .q_bit       (stepBit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      prem_q     <= '0;
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      prem_q     <= prem_d;
      count_q    <= count_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    prem_d     = prem_q;
    count_d    = count_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (start) begin
          dz_d = 1'b0;
          // A zero divisor skips iteration and publishes the fixed result at once.
          if (in_b == '0) begin
            state_d = DIV_DONE;
            quot_d  = DIV_ZERO_QUOT[size-1:0];
            rem_d   = in_a;
            dz_d    = 1'b1;
          end else begin
            state_d    = DIV_CALC;
            dividend_d = in_a;
            divisor_d  = in_b;
            prem_d     = '0;
            count_d    = CW'(size - 1);
          end
        end
      end

      DIV_CALC: begin
        dividend_d = {dividend_q[size-2:0], stepBit};
        prem_d     = stepRem;
        if (count_q == '0) begin
          state_d = DIV_DONE;
          quot_d  = {dividend_q[size-2:0], stepBit};
          rem_d   = stepRem[size-1:0];
        end else begin
          count_d = count_q - CW'(1);
        end
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  assign busy      = (state_q == DIV_CALC);
  assign done      = (state_q == DIV_DONE);
  assign div_zero  = dz_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (size=4): directed table, hand-written
// handshake sequences and an exhaustive sweep, all scored on the done pulse.
module tb_div_seq_ctrl;

  localparam int SIZE = 4;

  logic            clk;
  logic            reset;
  logic            start;
  logic [SIZE-1:0] in_a;
  logic [SIZE-1:0] in_b;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;

  div_seq_ctrl #(
    .size(SIZE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_a     (in_a),
    .in_b     (in_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            dz;
  } vec_t;

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            dz;
    int              sEdge;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[8];
  int   checks = 0;
  int   passes = 0;
  int   edgeCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drives a start for one cycle from a falling edge and records what the done pulse must show.
  task automatic applyStimulus(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                               input logic [SIZE-1:0] q, input logic [SIZE-1:0] r,
                               input logic dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
    e.sEdge = edgeCount + 1;
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    sbQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40; i++) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
    end
    if (sbQ.size() != 0) begin
      checkOutput("drainTimeout", sbQ.size(), 0);
      sbQ.delete();
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("quotient", int'(quotient), int'(e.q));
        checkOutput("remainder", int'(remainder), int'(e.r));
        checkOutput("divZero", int'(div_zero), int'(e.dz));
        checkOutput("doneCycle", edgeCount - e.sEdge + 1, (e.b == 0) ? 1 : SIZE + 1);
        if (e.b != 0) begin
          checkOutput("invariant", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
          checkOutput("remLtDiv", int'(remainder < e.b), 1);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstDivZero", int'(div_zero), 0);
    checkOutput("rstQuot", int'(quotient), 0);
    checkOutput("rstRem", int'(remainder), 0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1,  dz: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  dz: 1'b0};
    vecs[2] = '{a: 4'd3,  b: 4'd5,  q: 4'd0,  r: 4'd3,  dz: 1'b0};
    vecs[3] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7,  dz: 1'b1};
    vecs[4] = '{a: 4'd10, b: 4'd4,  q: 4'd2,  r: 4'd2,  dz: 1'b0};
    vecs[5] = '{a: 4'd0,  b: 4'd7,  q: 4'd0,  r: 4'd0,  dz: 1'b0};
    vecs[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0,  dz: 1'b0};
    vecs[7] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0,  dz: 1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
      waitDrain();
      @(negedge clk);
    end

    // 13/3: busy for exactly four cycles before the done pulse.
    applyStimulus(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    for (int i = 1; i <= SIZE; i++) begin
      checkOutput("busyCalc", int'(busy), 1);
      checkOutput("noEarlyDone", int'(done), 0);
      @(negedge clk);
    end
    checkOutput("busyInDone", int'(busy), 0);
    waitDrain();
    @(negedge clk);

    // 15/1 followed by 3/5 launched in the DONE cycle.
    applyStimulus(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    checkOutput("b2bDoneSeen", int'(done), 1);
    applyStimulus(4'd3, 4'd5, 4'd0, 4'd3, 1'b0);
    checkOutput("b2bAccepted", int'(busy), 1);
    waitDrain();
    @(negedge clk);

    // Zero divisor: immediate done, never busy; the next start clears div_zero.
    applyStimulus(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    checkOutput("dzNotBusy", int'(busy), 0);
    checkOutput("dzFlag", int'(div_zero), 1);
    waitDrain();
    @(negedge clk);
    checkOutput("dzHeld", int'(div_zero), 1);
    applyStimulus(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
    checkOutput("dzCleared", int'(div_zero), 0);
    waitDrain();
    @(negedge clk);

    // Start while busy is ignored.
    applyStimulus(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    in_a  = 4'd9;
    in_b  = 4'd9;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    @(negedge clk);

    // Reset mid-calculation abandons the op without a done pulse.
    applyStimulus(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sbQ.delete();
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstDone", int'(done), 0);
    checkOutput("midRstQuot", int'(quotient), 0);
    checkOutput("midRstRem", int'(remainder), 0);
    repeat (SIZE + 2) @(negedge clk);
    applyStimulus(4'd10, 4'd4, 4'd2, 4'd2, 1'b0);
    waitDrain();
    @(negedge clk);

    // Exhaustive sweep against a division model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
        waitDrain();
      end
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
